// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back queue.
// Entry layout and pointer sizing are common to the queue and its forwarding matchers.
package wb_pkg;

  localparam int WB_DEPTH      = 4;
  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 32;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  // A single-entry queue would still need a one-bit pointer to stay legal.
  function automatic int wb_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-first match of one decode read address against the pending queue entries.
// Validity and age come from the head pointer and occupancy, so no per-entry valid bits exist.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH      = WB_DEPTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int PW         = wb_ptr_w(WB_DEPTH),
  parameter int CW         = $clog2(WB_DEPTH + 1)
) (
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr_i,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data_i,
  input  logic [PW-1:0]                    rd_ptr_i,
  input  logic [CW-1:0]                    count_i,
  input  logic [ADDR_WIDTH-1:0]            rs_addr_i,
  output logic                             hit_o,
  output logic [DATA_WIDTH-1:0]            data_o
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest; a later match overwrites an earlier one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_i + PW'(k);
      if ((CW'(k) < count_i) && (rs_addr_i != '0) && (ent_addr_i[idx] == rs_addr_i)) begin
        hit_o  = 1'b1;
        data_o = ent_data_i[idx];
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// In-order write-back FIFO feeding the register file's shared write port, drained only
// on cycles the pipeline leaves the port free, with decode-stage forwarding lookups.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DEPTH      = WB_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [ADDR_WIDTH-1:0]        in_addr_i,
  input  logic [DATA_WIDTH-1:0]        in_data_i,
  input  logic                         drain_en_i,
  output logic                         rd_wren_o,
  output logic [ADDR_WIDTH-1:0]        rd_addr_o,
  output logic [DATA_WIDTH-1:0]        rd_data_o,
  input  logic [ADDR_WIDTH-1:0]        rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0]        rs2_addr_i,
  output logic                         fwd1_hit_o,
  output logic                         fwd2_hit_o,
  output logic [DATA_WIDTH-1:0]        fwd1_data_o,
  output logic [DATA_WIDTH-1:0]        fwd2_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);

  localparam int PW    = wb_ptr_w(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int NPORT = 2;

  wb_entry_t       mem_q [DEPTH];
  wb_entry_t       mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  logic            push, keep, pop;
  wb_entry_t       head, wr_entry;

  assign empty_o    = (count_q == '0);
  assign in_ready_o = (count_q < CW'(DEPTH));
  assign count_o    = count_q;

  assign head      = mem_q[rd_ptr_q];
  assign rd_wren_o = !empty_o && drain_en_i;
  assign rd_addr_o = ADDR_WIDTH'(head.addr);
  assign rd_data_o = DATA_WIDTH'(head.data);

  assign push = in_valid_i && in_ready_o;
  // x0 results complete the handshake but never occupy a slot.
  assign keep = push && (in_addr_i != '0);
  assign pop  = rd_wren_o;

  assign wr_entry.addr = WB_ADDR_WIDTH'(in_addr_i);
  assign wr_entry.data = WB_DATA_WIDTH'(in_data_i);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (keep) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({keep, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // Flattened view of storage for the matchers; the entry being pushed is not yet in mem_q.
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data;

  for (genvar e = 0; e < DEPTH; e++) begin : g_flat
    assign ent_addr[e] = ADDR_WIDTH'(mem_q[e].addr);
    assign ent_data[e] = DATA_WIDTH'(mem_q[e].data);
  end

  logic [NPORT-1:0][ADDR_WIDTH-1:0] rs_addr;
  logic [NPORT-1:0]                 fwd_hit;
  logic [NPORT-1:0][DATA_WIDTH-1:0] fwd_data;

  assign rs_addr = {rs2_addr_i, rs1_addr_i};

  for (genvar p = 0; p < NPORT; p++) begin : g_fwd
    wb_fwd_match #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .PW         (PW),
      .CW         (CW)
    ) u_match (
      .ent_addr_i (ent_addr),
      .ent_data_i (ent_data),
      .rd_ptr_i   (rd_ptr_q),
      .count_i    (count_q),
      .rs_addr_i  (rs_addr[p]),
      .hit_o      (fwd_hit[p]),
      .data_o     (fwd_data[p])
    );
  end

  assign fwd1_hit_o  = fwd_hit[0];
  assign fwd2_hit_o  = fwd_hit[1];
  assign fwd1_data_o = fwd_data[0];
  assign fwd2_data_o = fwd_data[1];

endmodule

// File: tb/tb_wb_queue.sv
// Write-back queue bench: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a queue-based reference model.
module tb_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic [4:0]  in_addr_i = '0;
  logic [31:0] in_data_i = '0;
  logic        drain_en_i = 1'b1;
  logic [4:0]  rs1_addr_i = '0, rs2_addr_i = '0;
  logic        in_ready_o, rd_wren_o, fwd1_hit_o, fwd2_hit_o, empty_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o, fwd1_data_o, fwd2_data_o;
  logic [2:0]  count_o;

  wb_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_addr_i(in_addr_i), .in_data_i(in_data_i),
    .drain_en_i(drain_en_i),
    .rd_wren_o(rd_wren_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .fwd1_hit_o(fwd1_hit_o), .fwd2_hit_o(fwd2_hit_o),
    .fwd1_data_o(fwd1_data_o), .fwd2_data_o(fwd2_data_o),
    .count_o(count_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending (addr, data) pairs, oldest first.
  typedef struct packed { logic [4:0] a; logic [31:0] d; } ment_t;
  ment_t mq[$];
  bit    started = 1'b0;

  function automatic void mfwd(input logic [4:0] rs, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (rs != 5'd0)
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].a == rs) begin
          hit = 1'b1;
          d   = mq[i].d;
        end
  endfunction

  task automatic model_step();
    bit rdy, wr;
    if (rst_i) begin
      mq.delete();
      started = 1'b1;
    end else if (started) begin
      rdy = mq.size() < DEPTH;
      wr  = (mq.size() > 0) && drain_en_i;
      if (wr) void'(mq.pop_front());
      if (in_valid_i && rdy && in_addr_i != 5'd0) mq.push_back('{a: in_addr_i, d: in_data_i});
    end
  endtask

  always @(posedge clk) model_step();

  task automatic compare();
    logic        h;
    logic [31:0] d;
    chk("count", 32'(count_o), 32'(mq.size()));
    chk("empty", 32'(empty_o), 32'(mq.size() == 0));
    chk("in_ready", 32'(in_ready_o), 32'(mq.size() < DEPTH));
    chk("rd_wren", 32'(rd_wren_o), 32'((mq.size() > 0) && drain_en_i));
    if (mq.size() > 0) begin
      chk("rd_addr", 32'(rd_addr_o), 32'(mq[0].a));
      chk("rd_data", rd_data_o, mq[0].d);
    end
    mfwd(rs1_addr_i, h, d);
    chk("fwd1_hit", 32'(fwd1_hit_o), 32'(h));
    chk("fwd1_data", fwd1_data_o, d);
    mfwd(rs2_addr_i, h, d);
    chk("fwd2_hit", 32'(fwd2_hit_o), 32'(h));
    chk("fwd2_data", fwd2_data_o, d);
  endtask

  always @(negedge clk) if (started) compare();

  // Producer must hold a rejected request unchanged until it is taken.
  ap_hold: assert property (@(posedge clk) disable iff (rst_i)
    (in_valid_i && !in_ready_o) |=> (in_valid_i && $stable(in_addr_i) && $stable(in_data_i)))
    else $error("producer hold rule violated");

  task automatic cyc(input bit r, input bit v, input logic [4:0] a, input logic [31:0] d,
                     input bit dr, input logic [4:0] s1, input logic [4:0] s2);
    @(posedge clk);
    #1;
    rst_i = r; in_valid_i = v; in_addr_i = a; in_data_i = d;
    drain_en_i = dr; rs1_addr_i = s1; rs2_addr_i = s2;
    @(negedge clk);
  endtask

  initial begin
    bit          acc, v;
    logic [4:0]  a;
    logic [31:0] d;

    // Reset with the write port offered: nothing may be written.
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("rst_wren", 32'(rd_wren_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_ready", 32'(in_ready_o), 32'd1);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_fwd1", 32'(fwd1_hit_o), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    chk("rst_rd_data", rd_data_o, 32'd0);

    // Fill to full, stall x9, then drain in order.
    cyc(0, 1, 5, 32'h11, 0, 0, 0);
    cyc(0, 1, 6, 32'h22, 0, 0, 0);
    cyc(0, 1, 7, 32'h33, 0, 0, 0);
    cyc(0, 1, 8, 32'h44, 0, 0, 0);
    cyc(0, 1, 9, 32'h55, 0, 5, 0);
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_ready", 32'(in_ready_o), 32'd0);
    chk("full_fwd_x5", fwd1_data_o, 32'h11);
    cyc(0, 1, 9, 32'h55, 1, 0, 0);
    chk("drain0_addr", 32'(rd_addr_o), 32'd5);
    chk("drain0_ready", 32'(in_ready_o), 32'd0);
    cyc(0, 1, 9, 32'h55, 1, 0, 0);
    chk("drain1_addr", 32'(rd_addr_o), 32'd6);
    chk("drain1_ready", 32'(in_ready_o), 32'd1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("drain2_addr", 32'(rd_addr_o), 32'd7);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("drain3_addr", 32'(rd_addr_o), 32'd8);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("drain4_addr", 32'(rd_addr_o), 32'd9);
    chk("drain4_data", rd_data_o, 32'h55);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("drained_empty", 32'(empty_o), 32'd1);

    // Youngest match wins; the entry being pushed is not yet visible.
    cyc(0, 1, 3, 32'hAAAA, 0, 0, 0);
    cyc(0, 1, 3, 32'hBBBB, 0, 3, 4);
    chk("fwd_inflight", fwd1_data_o, 32'hAAAA);
    cyc(0, 0, 0, 0, 0, 3, 4);
    chk("fwd1_hit", 32'(fwd1_hit_o), 32'd1);
    chk("fwd1_young", fwd1_data_o, 32'hBBBB);
    chk("fwd2_miss", 32'(fwd2_hit_o), 32'd0);
    chk("fwd2_zero", fwd2_data_o, 32'd0);
    cyc(0, 0, 0, 0, 1, 3, 4);
    cyc(0, 0, 0, 0, 1, 3, 4);
    chk("fwd_popping_head", fwd1_data_o, 32'hBBBB);
    cyc(0, 0, 0, 0, 1, 3, 4);
    chk("fwd_after_drain", 32'(fwd1_hit_o), 32'd0);

    // x0 result is taken and dropped.
    cyc(0, 1, 0, 32'hDEAD, 1, 0, 0);
    chk("x0_ready", 32'(in_ready_o), 32'd1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("x0_count", 32'(count_o), 32'd0);
    chk("x0_wren", 32'(rd_wren_o), 32'd0);
    chk("x0_fwd", 32'(fwd1_hit_o), 32'd0);

    // Steady push+pop at occupancy 2 across several pointer wraps.
    cyc(0, 1, 10, 32'd100, 0, 0, 0);
    cyc(0, 1, 11, 32'd101, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 5'(12 + i), 32'(102 + i), 1, 0, 0);
      chk("pp_count", 32'(count_o), 32'd2);
      chk("pp_addr", 32'(rd_addr_o), 32'(10 + i));
      chk("pp_data", rd_data_o, 32'(100 + i));
    end

    // Reset with three entries pending.
    cyc(0, 1, 22, 32'd112, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 20, 21);
    chk("pre_rst_count", 32'(count_o), 32'd3);
    chk("pre_rst_fwd1", fwd1_data_o, 32'd110);
    chk("pre_rst_fwd2", fwd2_data_o, 32'd111);
    cyc(1, 0, 0, 0, 1, 20, 21);
    cyc(0, 0, 0, 0, 1, 20, 21);
    chk("mid_rst_count", 32'(count_o), 32'd0);
    chk("mid_rst_wren", 32'(rd_wren_o), 32'd0);
    chk("mid_rst_fwd1", 32'(fwd1_hit_o), 32'd0);
    chk("mid_rst_fwd2", 32'(fwd2_hit_o), 32'd0);
    cyc(0, 0, 0, 0, 1, 20, 21);
    chk("mid_rst_wren2", 32'(rd_wren_o), 32'd0);

    // Random traffic against the model, honouring the producer hold rule.
    v = 1'b0; a = '0; d = '0;
    for (int n = 0; n < 800; n++) begin
      acc = in_valid_i && in_ready_o;
      if (!in_valid_i || acc || rst_i) begin
        v = ($urandom_range(0, 99) < 60);
        a = 5'($urandom_range(0, 7));
        d = $urandom;
      end
      cyc(($urandom_range(0, 199) == 0), v, a, d, ($urandom_range(0, 99) < 45),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
# wb_queue

Write-back queue for the register file's single write port. Completed results from multi-cycle producers (load unit, future MUL/DIV) are buffered in a small in-order FIFO and drained into `regfile` (`rd_wren`/`rd_addr`/`rd_data`) only on cycles when the main pipeline leaves the write port free. It also provides forwarding lookups so decode reads of pending destinations return the queued value instead of stale register contents.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data width of each result.
- `ADDR_WIDTH`, 5, register address width.
- `DEPTH`, 4, number of queue entries; power of two, at least 2.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `in_valid_i`  in  1  producer has a result.
- `in_ready_o`  out  1  queue can accept; equals `count_o < DEPTH`.
- `in_addr_i`  in  ADDR_WIDTH  destination register.
- `in_data_i`  in  DATA_WIDTH  result value.
- `drain_en_i`  in  1  the write port is free this cycle.
- `rd_wren_o`  out  1  write enable to `regfile` `rd_wren`.
- `rd_addr_o`  out  ADDR_WIDTH  to `regfile` `rd_addr`.
- `rd_data_o`  out  DATA_WIDTH  to `regfile` `rd_data`.
- `rs1_addr_i`, `rs2_addr_i`  in  ADDR_WIDTH  decode-stage read addresses.
- `fwd1_hit_o`, `fwd2_hit_o`  out  1  a pending entry matches the corresponding read address.
- `fwd1_data_o`, `fwd2_data_o`  out  DATA_WIDTH  matched value; 0 when there is no hit.
- `count_o`  out  $clog2(DEPTH+1)  number of valid entries.
- `empty_o`  out  1  `count_o == 0`.

## Operation
- Push: the queue accepts an entry when `in_valid_i && in_ready_o`. It is written at `wr_ptr`, and `wr_ptr` increments.
- Push with `in_addr_i == 0`: handshake completes, the entry is discarded, and `count_o` does not change.
- Pop: occurs when `rd_wren_o` is high. `rd_wren_o = !empty_o && drain_en_i`, which is combinational. `rd_addr_o`/`rd_data_o` always show the head entry. `rd_ptr` increments on a pop.
- Pointers wrap modulo `DEPTH`. Entries drain strictly in order.
- Push and pop in the same cycle: both happen and `count_o` is unchanged.
- Full (`count_o == DEPTH`): `in_ready_o = 0` even if a pop occurs this cycle. There is no full pass-through.
- Empty with a push: there is no bypass to `rd_*`. The entry becomes drainable the next cycle.
- Forwarding scope: the search covers all valid entries, including the head being popped this cycle. The youngest matching entry wins.
- Forwarding exclusions: address 0 never hits. An entry being pushed in the same cycle is not searched.
- Reset mid-operation: all pending entries are discarded. Pointers and count go to 0.
- Producer rule: it must hold `in_valid_i`, `in_addr_i` and `in_data_i` stable until accepted. The bench checks this with an assertion.

## Timing
- Reset values (cycle after `rst_i` is sampled high):
  - `count_o = 0`, `empty_o = 1`, `in_ready_o = 1`.
  - `rd_wren_o = 0` regardless of `drain_en_i`.
  - `fwd*_hit_o = 0`, `fwd*_data_o = 0`.
  - `rd_addr_o`/`rd_data_o` = 0; entry storage is cleared.
- Latency: an entry accepted at edge N is visible on `rd_*` and to forwarding from edge N onward. It can be written to `regfile` in cycle N+1 at the earliest.
- Write-port timing: `regfile` samples its write port on the falling clock edge. `rd_*` outputs are stable from the rising edge plus combinational delay on `drain_en_i`.
- Forwarding outputs are purely combinational from the read addresses and the current state.

## Structure
- Package `wb_pkg` holds:
  - `wb_entry_t` packed struct {addr[ADDR_WIDTH], data[DATA_WIDTH]};
  - the default `WB_DEPTH` constant;
  - a function computing the pointer width.
- Sub-module `wb_fwd_match`: a youngest-first priority match over the entry array for one read address. It is instantiated twice (rs1, rs2), taking `rd_ptr`/`count` to derive validity and age.
- Storage is a register array of `wb_entry_t`, plus the pointers and a count register.

## Test plan
- Reset then idle: `rst_i = 1` for 2 cycles with `drain_en_i = 1` → `rd_wren_o = 0`, `count_o = 0`, `in_ready_o = 1`, no forwarding hits.
- Fill and drain: push x5=0x11, x6=0x22, x7=0x33, x8=0x44 with `drain_en_i = 0`.
  - After the fourth push: `count_o = 4` and `in_ready_o = 0`.
  - A fifth push of x9 stalls.
  - Then raise `drain_en_i` → `rd_*` writes x5, x6, x7, x8 on consecutive cycles, then x9.
- Forward priority: queue x3=0xAAAA then x3=0xBBBB, with `rs1_addr_i = 3` and `rs2_addr_i = 4` → `fwd1_hit_o = 1` with data 0xBBBB, and `fwd2_hit_o = 0`.
- x0 discard: push x0=0xDEAD → accepted with `in_ready_o = 1`, `count_o` unchanged, `rs1_addr_i = 0` gives no hit, and no write occurs.
- Simultaneous push/pop with wrap: keep `count_o = 2` while pushing and draining every cycle for 10 cycles → `count_o` stays 2, writes are in order, and pointers wrap without loss.
- Reset mid-operation: with 3 entries pending, assert `rst_i` for 1 cycle → `count_o = 0`, no further `rd_wren_o`, and forwarding hits clear.
